// File: rtl/io_load_queue.sv
// io_load_queue: in-order tracker for outstanding data-SRAM accesses, aligning load data and retiring to WB.
// Optional feature macro IO_LOAD_QUEUE_BYPASS_EN: a head-load response drives wb_* in its own cycle.
module io_load_queue #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned PC_WIDTH       = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      issue_valid,
   output logic                      issue_ready,
   input  logic                      issue_is_store,
   input  logic [1:0]                issue_size,
   input  logic                      issue_unsigned,
   input  logic                      issue_left,
   input  logic                      issue_right,
   input  logic [1:0]                issue_addr_low,
   input  logic [REG_ADDR_WIDTH-1:0] issue_dest,
   input  logic [PC_WIDTH-1:0]       issue_pc,
   input  logic                      flush,
   input  logic                      data_ram_data_ready,
   input  logic [31:0]               data_ram_read_data,
   output logic                      wb_valid,
   input  logic                      wb_ready,
   output logic [PC_WIDTH-1:0]       wb_program_count,
   output logic [REG_ADDR_WIDTH-1:0] wb_register,
   output logic [3:0]                wb_strobe,
   output logic [31:0]               wb_data,
   output logic [$clog2(DEPTH):0]    outstanding_count,
   output logic                      resp_orphan
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {FREE, PENDING, DONE, KILLED} entry_state_t;

   typedef struct packed {
      logic                      is_store;
      logic [1:0]                size;
      logic                      is_unsigned;
      logic                      left;
      logic                      right;
      logic [1:0]                addr_low;
      logic [REG_ADDR_WIDTH-1:0] dest;
      logic [PC_WIDTH-1:0]       pc;
   } meta_t;

   entry_state_t   state   [DEPTH];
   entry_state_t   state_n [DEPTH];
   meta_t          meta    [DEPTH];
   logic [31:0]    data    [DEPTH];
   logic [3:0]     strb    [DEPTH];

   logic [PW-1:0]  head, head_n, resp, resp_n, tail, tail_n;
   logic [CW-1:0]  count, count_n;
   logic           orphan_n;
   logic           alloc, fill, bypass;

   meta_t          rm;
   logic [7:0]     lane_byte;
   logic [15:0]    lane_half;
   logic [31:0]    ext_data;
   logic [3:0]     ext_strobe;

   assign issue_ready       = (count < CW'(DEPTH));
   assign outstanding_count = count;

   // Data extraction for the entry awaiting the current response.
   always_comb begin
      rm         = meta[resp];
      lane_byte  = data_ram_read_data[{rm.addr_low, 3'b000} +: 8];
      lane_half  = rm.addr_low[1] ? data_ram_read_data[31:16] : data_ram_read_data[15:0];
      ext_data   = data_ram_read_data;
      ext_strobe = 4'b1111;
      if (rm.left) begin
         ext_data   = data_ram_read_data << {2'd3 - rm.addr_low, 3'b000};
         ext_strobe = 4'b1111 << (2'd3 - rm.addr_low);
      end else if (rm.right) begin
         ext_data   = data_ram_read_data >> {rm.addr_low, 3'b000};
         ext_strobe = 4'b1111 >> rm.addr_low;
      end else begin
         case (rm.size)
            2'd0:    ext_data = {{24{!rm.is_unsigned & lane_byte[7]}}, lane_byte};
            2'd1:    ext_data = {{16{!rm.is_unsigned & lane_half[15]}}, lane_half};
            default: ext_data = data_ram_read_data;
         endcase
      end
   end

`ifdef IO_LOAD_QUEUE_BYPASS_EN
   assign bypass = data_ram_data_ready && !flush && (state[resp] == PENDING) &&
                   (head == resp) && !meta[resp].is_store;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) state_n[i] = state[i];
      head_n   = head;
      resp_n   = resp;
      tail_n   = tail;
      orphan_n = resp_orphan;
      alloc    = 1'b0;
      fill     = 1'b0;

      if (flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (state[i] == DONE)         state_n[i] = FREE;
            else if (state[i] == PENDING) state_n[i] = KILLED;
         end
      end else if (state[head] == DONE && (meta[head].is_store || wb_ready)) begin
         state_n[head] = FREE;
         head_n        = head + 1'b1;
      end

      // Killed entries always sit at head==resp, so freeing one drags head along.
      if (data_ram_data_ready) begin
         if (state[resp] == PENDING || state[resp] == KILLED) begin
            resp_n = resp + 1'b1;
            if (state[resp] == KILLED || flush) begin
               state_n[resp] = FREE;
               if (head == resp) head_n = resp_n;
            end else if (bypass && wb_ready) begin
               state_n[resp] = FREE;
               head_n        = resp_n;
            end else begin
               state_n[resp] = DONE;
               fill          = 1'b1;
            end
         end else begin
            orphan_n = 1'b1;
         end
      end

      if (flush) begin
         head_n = resp_n;
      end else if (issue_valid && issue_ready) begin
         state_n[tail] = PENDING;
         tail_n        = tail + 1'b1;
         alloc         = 1'b1;
      end

      count_n = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         if (state_n[i] != FREE) count_n = count_n + 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            state[i] <= FREE;
            meta[i]  <= '0;
            data[i]  <= '0;
            strb[i]  <= '0;
         end
         head        <= '0;
         resp        <= '0;
         tail        <= '0;
         count       <= '0;
         resp_orphan <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) state[i] <= state_n[i];
         head        <= head_n;
         resp        <= resp_n;
         tail        <= tail_n;
         count       <= count_n;
         resp_orphan <= orphan_n;
         if (alloc) begin
            meta[tail] <= '{is_store: issue_is_store, size: issue_size,
                            is_unsigned: issue_unsigned, left: issue_left,
                            right: issue_right, addr_low: issue_addr_low,
                            dest: issue_dest, pc: issue_pc};
         end
         if (fill) begin
            data[resp] <= ext_data;
            strb[resp] <= ext_strobe;
         end
      end
   end

   always_comb begin
      wb_valid         = (state[head] == DONE && !meta[head].is_store) || bypass;
      wb_program_count = '0;
      wb_register      = '0;
      wb_strobe        = '0;
      wb_data          = '0;
      if (wb_valid) begin
         wb_program_count = meta[head].pc;
         wb_register      = meta[head].dest;
         wb_strobe        = bypass ? ext_strobe : strb[head];
         wb_data          = bypass ? ext_data   : data[head];
      end
   end

endmodule
